// File: rtl/fc_operand_streamer.sv
// fc_operand_streamer: buffers one activation/weight vector and streams it as valid/ready beats
module fc_operand_streamer #(
  parameter int NUM_INPUTS = 8,
  parameter int DATA_W = 16,
  localparam int IDX_W = $clog2(NUM_INPUTS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_addr,
  input  logic signed [DATA_W-1:0] wr_act,
  input  logic signed [DATA_W-1:0] wr_wt,
  input  logic                     start,
  output logic                     busy,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic signed [DATA_W-1:0] tx_act,
  output logic signed [DATA_W-1:0] tx_wt,
  output logic [IDX_W-1:0]         tx_idx,
  output logic                     tx_last,
  output logic                     done
);
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
  state_t state;
  logic [IDX_W-1:0] idx;
  logic signed [DATA_W-1:0] act_mem [NUM_INPUTS];
  logic signed [DATA_W-1:0] wt_mem [NUM_INPUTS];
  logic last;
  assign last = idx == IDX_W'(NUM_INPUTS - 1);
  assign busy = state != IDLE;
  assign tx_valid = state == STREAM;
  assign done = state == DONE;
  assign tx_last = tx_valid & last;
  assign tx_act = tx_valid ? act_mem[idx] : '0;
  assign tx_wt = tx_valid ? wt_mem[idx] : '0;
  assign tx_idx = tx_valid ? idx : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        act_mem[i] <= '0;
        wt_mem[i] <= '0;
      end
    end else begin
      if (state == IDLE && wr_en && 32'(wr_addr) < NUM_INPUTS) begin
        act_mem[wr_addr] <= wr_act;
        wt_mem[wr_addr] <= wr_wt;
      end
      case (state)
        IDLE: if (start) begin
          state <= STREAM;
          idx <= '0;
        end
        STREAM: if (tx_ready) begin
          if (last) state <= DONE;
          else idx <= idx + 1'b1;
        end
        default: begin
          state <= IDLE;
          idx <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fc_operand_streamer.sv
// tb_fc_operand_streamer: directed and random checks of the operand streamer against a beat-level model
module tb_fc_operand_streamer;
  logic clk = 0, rst = 1;
  logic wr_en = 0, start = 0, tx_ready = 0;
  logic [2:0] wr_addr = 0;
  logic signed [15:0] wr_act = 0, wr_wt = 0;
  logic busy, tx_valid, tx_last, done;
  logic signed [15:0] tx_act, tx_wt;
  logic [2:0] tx_idx;
  logic b_wr_en = 0, b_start = 0, b_tx_ready = 1;
  logic [0:0] b_wr_addr = 0;
  logic signed [15:0] b_wr_act = 0, b_wr_wt = 0;
  logic b_busy, b_tx_valid, b_tx_last, b_done;
  logic signed [15:0] b_tx_act, b_tx_wt;
  logic [0:0] b_tx_idx;
  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;
  always #5 clk = ~clk;
  fc_operand_streamer #(.NUM_INPUTS(8), .DATA_W(16)) u8 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_act(wr_act), .wr_wt(wr_wt),
    .start(start), .busy(busy), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_act(tx_act),
    .tx_wt(tx_wt), .tx_idx(tx_idx), .tx_last(tx_last), .done(done));
  fc_operand_streamer #(.NUM_INPUTS(2), .DATA_W(16)) u2 (
    .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_act(b_wr_act), .wr_wt(b_wr_wt),
    .start(b_start), .busy(b_busy), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .tx_act(b_tx_act),
    .tx_wt(b_tx_wt), .tx_idx(b_tx_idx), .tx_last(b_tx_last), .done(b_done));
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("done_timeout", 32'(n < 100), 1);
    step();
  endtask
  // Model: live buffer, plus a snapshot taken at start that the run streams from
  logic signed [15:0] m_act [8], m_wt [8], s_act [8], s_wt [8];
  int phase = 0, sent = 0;
  always @(posedge clk) begin
    if (rst) begin
      phase = 0;
      sent = 0;
      foreach (m_act[i]) begin
        m_act[i] = 0;
        m_wt[i] = 0;
      end
    end else if (phase == 1) begin
      if (tx_ready) begin
        sent++;
        if (sent == 8) phase = 2;
      end
    end else if (phase == 2) begin
      phase = 0;
      sent = 0;
    end else begin
      if (wr_en) begin
        m_act[wr_addr] = wr_act;
        m_wt[wr_addr] = wr_wt;
      end
      if (start) begin
        s_act = m_act;
        s_wt = m_wt;
        sent = 0;
        phase = 1;
      end
    end
  end
  always @(negedge clk) if (chk_en) begin
    bit v;
    v = phase == 1;
    chk("valid", 32'(tx_valid), 32'(v));
    chk("busy", 32'(busy), 32'(phase != 0));
    chk("done", 32'(done), 32'(phase == 2));
    chk("idx", 32'(tx_idx), v ? 32'(sent) : 0);
    chk("last", 32'(tx_last), 32'(v && sent == 7));
    chk("act", 32'(tx_act), v ? 32'(s_act[sent]) : 0);
    chk("wt", 32'(tx_wt), v ? 32'(s_wt[sent]) : 0);
  end
  initial begin
    step();
    chk_en = 1;
    step();
    chk("rst_valid", 32'(tx_valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 0;
    start = 1;
    step();
    start = 0;
    tx_ready = 1;
    chk("t1_valid", 32'(tx_valid), 1);
    chk("t1_act", 32'(tx_act), 0);
    chk("t1_busy", 32'(busy), 1);
    wait_done();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1;
      wr_addr = 3'(i);
      wr_act = 16'(i + 1);
      wr_wt = 2;
      step();
    end
    wr_en = 0;
    start = 1;
    step();
    start = 0;
    for (int k = 0; k < 8; k++) begin
      chk("t2_valid", 32'(tx_valid), 1);
      chk("t2_idx", 32'(tx_idx), k);
      chk("t2_act", 32'(tx_act), k + 1);
      chk("t2_wt", 32'(tx_wt), 2);
      chk("t2_last", 32'(tx_last), 32'(k == 7));
      chk("t2_done", 32'(done), 0);
      step();
    end
    chk("t2_done_pulse", 32'(done), 1);
    chk("t2_valid_off", 32'(tx_valid), 0);
    step();
    chk("t2_done_clr", 32'(done), 0);
    chk("t2_busy_clr", 32'(busy), 0);
    start = 1;
    step();
    start = 0;
    for (int c = 0; c < 40 && done !== 1'b1; c++) begin
      tx_ready = c % 2 == 0;
      step();
    end
    chk("t3_done", 32'(done), 1);
    tx_ready = 1;
    step();
    start = 1;
    step();
    start = 0;
    repeat (2) step();
    chk("t4_beat2", 32'(tx_idx), 2);
    wr_en = 1;
    wr_addr = 3;
    wr_act = 99;
    wr_wt = 7;
    start = 1;
    step();
    wr_en = 0;
    start = 0;
    chk("t4_beat3_act", 32'(tx_act), 4);
    chk("t4_beat3_wt", 32'(tx_wt), 2);
    wait_done();
    start = 1;
    step();
    start = 0;
    repeat (3) step();
    chk("t4_rerun_idx", 32'(tx_idx), 3);
    chk("t4_rerun_act", 32'(tx_act), 4);
    wait_done();
    start = 1;
    step();
    start = 0;
    repeat (4) step();
    chk("t5_beat4", 32'(tx_idx), 4);
    rst = 1;
    step();
    rst = 0;
    chk("t5_valid", 32'(tx_valid), 0);
    chk("t5_busy", 32'(busy), 0);
    step();
    chk("t5_no_done", 32'(done), 0);
    start = 1;
    step();
    start = 0;
    chk("t5_zero_valid", 32'(tx_valid), 1);
    chk("t5_zero_act", 32'(tx_act), 0);
    wait_done();
    b_wr_en = 1;
    b_wr_addr = 1;
    b_wr_act = 5;
    b_wr_wt = -6;
    step();
    b_wr_addr = 0;
    b_wr_act = -3;
    b_wr_wt = 4;
    b_start = 1;
    step();
    b_wr_en = 0;
    b_start = 0;
    chk("t6_b0_valid", 32'(b_tx_valid), 1);
    chk("t6_b0_idx", 32'(b_tx_idx), 0);
    chk("t6_b0_act", 32'(b_tx_act), -3);
    chk("t6_b0_wt", 32'(b_tx_wt), 4);
    chk("t6_b0_last", 32'(b_tx_last), 0);
    step();
    chk("t6_b1_idx", 32'(b_tx_idx), 1);
    chk("t6_b1_act", 32'(b_tx_act), 5);
    chk("t6_b1_wt", 32'(b_tx_wt), -6);
    chk("t6_b1_last", 32'(b_tx_last), 1);
    step();
    chk("t6_done", 32'(b_done), 1);
    chk("t6_valid_off", 32'(b_tx_valid), 0);
    step();
    chk("t6_done_clr", 32'(b_done), 0);
    chk("t6_busy_clr", 32'(b_busy), 0);
    for (int c = 0; c < 1500; c++) begin
      rst = $urandom_range(0, 149) == 0;
      wr_en = $urandom_range(0, 2) == 0;
      wr_addr = 3'($urandom);
      wr_act = 16'($urandom);
      wr_wt = 16'($urandom);
      start = $urandom_range(0, 5) == 0;
      tx_ready = $urandom_range(0, 2) != 0;
      step();
    end
    rst = 0;
    wr_en = 0;
    start = 0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
